// File: rtl/nibble_serial_tx.sv
// -----------------------------------------------------------------------------
// nibble_serial_tx
//
// Takes nibbles from a show-ahead FIFO and shifts each one out on a single
// wire. A frame is a start bit (0), DATA_W data bits LSB first, an optional
// even-parity bit, and STOP_BITS stop bits (1). Every bit is held for
// CLKS_PER_BIT clocks. The line idles at 1.
//
// Optional feature macro: NIBBLE_TX_PARITY_EN
//   defined   -> a PARITY state follows the data bits and carries the XOR of
//                the captured nibble (even parity)
//   undefined -> there is no parity state or logic; STOP follows the data
//
// Parameters
//   DATA_W        data bits per frame (must match the FIFO width)
//   CLKS_PER_BIT  clocks per serial bit, >= 1
//   STOP_BITS     stop bits per frame, 1 or 2
//
// Ports
//   clk         in   rising-edge clock
//   rstN        in   asynchronous active-low reset
//   enable      in   1 = new frames may start
//   fifo_empty  in   FIFO empty flag
//   fifo_rdata  in   FIFO head data (show-ahead, valid while !fifo_empty)
//   fifo_rd_en  out  pop strobe, combinational, only ever high in IDLE
//   tx          out  serial line, registered
//   busy        out  high for every cycle of a frame, registered
//   frame_done  out  one-cycle pulse in the last cycle of the last stop bit
// -----------------------------------------------------------------------------
module nibble_serial_tx #(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rdata,
    output logic              fifo_rd_en,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    // Each counter is sized to hold its terminal value (at least 1 bit).
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_W > 1)       ? $clog2(DATA_W)       : 1;
    localparam int SW = (STOP_BITS > 1)    ? $clog2(STOP_BITS)    : 1;

    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_W - 1);
    localparam logic [SW-1:0] S_LAST = SW'(STOP_BITS - 1);

    generate
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("nibble_serial_tx: STOP_BITS must be 1 or 2");
        end
        if (CLKS_PER_BIT < 1) begin : g_bad_clks_per_bit
            $error("nibble_serial_tx: CLKS_PER_BIT must be >= 1");
        end
    endgenerate

`ifdef NIBBLE_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t            state, state_nx;
    logic [TW-1:0]     timer, timer_nx;
    logic [BW-1:0]     bit_cnt, bit_nx;
    logic [SW-1:0]     stop_cnt, stop_nx;
    logic [DATA_W-1:0] shift, shift_nx;
    logic              tx_nx, busy_nx, done_nx;
    logic              bit_end;
`ifdef NIBBLE_TX_PARITY_EN
    logic              par;
`endif

    // -------------------------------------------------------------------------
    // Next-state logic. The registered outputs are derived from the *next*
    // state so tx/busy/frame_done line up with the state they describe
    // rather than trailing it by one clock.
    // -------------------------------------------------------------------------
    always_comb begin
        state_nx   = state;
        timer_nx   = timer;
        bit_nx     = bit_cnt;
        stop_nx    = stop_cnt;
        shift_nx   = shift;
        fifo_rd_en = 1'b0;
        bit_end    = (timer == T_LAST);

        case (state)
            S_IDLE: begin
                fifo_rd_en = enable & ~fifo_empty;
                if (fifo_rd_en) begin
                    state_nx = S_START;
                    shift_nx = fifo_rdata;
                    timer_nx = '0;
                    bit_nx   = '0;
                    stop_nx  = '0;
                end
            end
            default: begin
                timer_nx = bit_end ? '0 : timer + 1'b1;
                if (bit_end) begin
                    case (state)
                        S_START: begin
                            state_nx = S_DATA;
                            bit_nx   = '0;
                        end
                        S_DATA: begin
                            shift_nx = shift >> 1;
                            if (bit_cnt == B_LAST) begin
`ifdef NIBBLE_TX_PARITY_EN
                                state_nx = S_PARITY;
`else
                                state_nx = S_STOP;
`endif
                                stop_nx  = '0;
                            end else begin
                                bit_nx = bit_cnt + 1'b1;
                            end
                        end
`ifdef NIBBLE_TX_PARITY_EN
                        S_PARITY: begin
                            state_nx = S_STOP;
                            stop_nx  = '0;
                        end
`endif
                        S_STOP: begin
                            if (stop_cnt == S_LAST)
                                state_nx = S_IDLE;
                            else
                                stop_nx = stop_cnt + 1'b1;
                        end
                        default: state_nx = S_IDLE;
                    endcase
                end
            end
        endcase

        // Line level for the coming cycle.
        case (state_nx)
            S_START:  tx_nx = 1'b0;
            S_DATA:   tx_nx = shift_nx[0];
`ifdef NIBBLE_TX_PARITY_EN
            S_PARITY: tx_nx = par;
`endif
            default:  tx_nx = 1'b1;
        endcase

        busy_nx = (state_nx != S_IDLE);
        // The pulse lands in the final clock of the final stop bit.
        done_nx = (state_nx == S_STOP) && (timer_nx == T_LAST) && (stop_nx == S_LAST);
    end

    // -------------------------------------------------------------------------
    // State and output registers. Reset drops any frame in flight; the nibble
    // already popped is simply lost.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state      <= S_IDLE;
            timer      <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= '0;
            shift      <= '0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            timer      <= timer_nx;
            bit_cnt    <= bit_nx;
            stop_cnt   <= stop_nx;
            shift      <= shift_nx;
            tx         <= tx_nx;
            busy       <= busy_nx;
            frame_done <= done_nx;
        end
    end

`ifdef NIBBLE_TX_PARITY_EN
    // Parity is taken from the nibble at pop time, before any shifting.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)
            par <= 1'b0;
        else if (fifo_rd_en)
            par <= ^fifo_rdata;
    end
`endif

endmodule

// File: tb/tb_nibble_serial_tx.sv
// -----------------------------------------------------------------------------
// Directed bench for nibble_serial_tx. Main instance: CLKS_PER_BIT=4,
// STOP_BITS=1 fed from a small FIFO model. Second instance: CLKS_PER_BIT=1,
// STOP_BITS=2, fed by hand.
// -----------------------------------------------------------------------------
module tb_nibble_serial_tx;

    localparam int CPB = 4;
`ifdef NIBBLE_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NCLK  = (1 + 4 + P + 1) * CPB;
    localparam int NCLK2 = (1 + 4 + P + 2);

    logic clk = 1'b0;
    logic rstN = 1'b1;
    logic enable = 1'b1;
    always #5 clk = ~clk;

    // Show-ahead FIFO model
    logic [3:0] mem [0:15];
    int wr_ptr = 0;
    int rd_ptr = 0;
    logic       fifo_empty;
    logic [3:0] fifo_rdata;
    logic       fifo_rd_en, tx, busy, frame_done;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_rdata = mem[rd_ptr[3:0]];
    always @(posedge clk) if (fifo_rd_en) rd_ptr <= rd_ptr + 1;

    logic       f2_empty = 1'b1;
    logic [3:0] f2_rdata = 4'h0;
    logic       f2_rd_en, tx2, busy2, done2;

    int checks = 0;
    int errors = 0;

    logic c_tx [0:127];
    logic c_busy [0:127];
    logic c_done [0:127];
    logic c_rd [0:127];

    nibble_serial_tx #(.DATA_W(4), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
        .clk(clk), .rstN(rstN), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata), .fifo_rd_en(fifo_rd_en), .tx(tx), .busy(busy),
        .frame_done(frame_done)
    );

    nibble_serial_tx #(.DATA_W(4), .CLKS_PER_BIT(1), .STOP_BITS(2)) dut2 (
        .clk(clk), .rstN(rstN), .enable(enable), .fifo_empty(f2_empty),
        .fifo_rdata(f2_rdata), .fifo_rd_en(f2_rd_en), .tx(tx2), .busy(busy2),
        .frame_done(done2)
    );

    // Expected line level in clock k (1-based) of a frame.
    function automatic logic exp_tx(input logic [3:0] d, input int k, input int cpb);
        int b;
        logic [1:0] bi;
        b = (k - 1) / cpb;
        if (b == 0) return 1'b0;
        if (b <= 4) begin
            bi = 2'(b - 1);
            return d[bi];
        end
        if (P == 1 && b == 5) return ^d;
        return 1'b1;
    endfunction

    task automatic push(input logic [3:0] d);
        mem[wr_ptr[3:0]] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    // Records n cycles of DUT outputs, sampled mid-cycle; idx 0 = current cycle.
    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            c_tx[i] = tx; c_busy[i] = busy; c_done[i] = frame_done; c_rd[i] = fifo_rd_en;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b exp=1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", frame_done); end
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got=%b exp=0", fifo_rd_en); end
        checks++; if (tx2 !== 1'b1 || busy2 !== 1'b0 || done2 !== 1'b0) begin
            errors++; $display("FAIL reset_dut2 got=%b%b%b exp=100", tx2, busy2, done2);
        end
    endtask

    task automatic test_idle_empty;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checks++;
            if (fifo_rd_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_empty cyc=%0d got rd/tx/busy=%b%b%b exp=010", i, fifo_rd_en, tx, busy);
            end
        end
    endtask

    task automatic test_single;
        int npop;
        logic [6:0] bits;
        push(4'hA);
        capture(NCLK + 2);
        npop = 0;
        for (int i = 0; i < NCLK + 2; i++) if (c_rd[i] === 1'b1) npop++;
        checks++; if (npop != 1 || c_rd[0] !== 1'b1) begin
            errors++; $display("FAIL single_pop got=%0d pops first=%b exp=1 pop at idx0", npop, c_rd[0]);
        end
        for (int k = 1; k <= NCLK; k++) begin
            checks++;
            if (c_tx[k] !== exp_tx(4'hA, k, CPB) || c_busy[k] !== 1'b1 || c_done[k] !== (k == NCLK)) begin
                errors++;
                $display("FAIL single_frame k=%0d got tx/busy/done=%b%b%b exp=%b1%b",
                         k, c_tx[k], c_busy[k], c_done[k], exp_tx(4'hA, k, CPB), (k == NCLK));
            end
        end
        checks++; if (c_tx[NCLK+1] !== 1'b1 || c_busy[NCLK+1] !== 1'b0 || c_done[NCLK+1] !== 1'b0) begin
            errors++; $display("FAIL single_after got=%b%b%b exp=100", c_tx[NCLK+1], c_busy[NCLK+1], c_done[NCLK+1]);
        end
        bits = '0;
        for (int b = 0; b < 6 + P; b++) bits[b] = c_tx[b*CPB + 2];
`ifdef NIBBLE_TX_PARITY_EN
        checks++; if (bits !== 7'b1010100) begin errors++; $display("FAIL single_bits got=%b exp=1010100", bits); end
`else
        checks++; if (bits[5:0] !== 6'b110100) begin errors++; $display("FAIL single_bits got=%b exp=110100", bits[5:0]); end
`endif
    endtask

    task automatic test_back_to_back(input logic [3:0] d0, input logic [3:0] d1,
                                     input logic [3:0] d2, input int nf);
        logic [3:0] dd [3];
        int n, f, k, npop, ndone;
        logic exp_rd, in_frame;
        dd[0] = d0; dd[1] = d1; dd[2] = d2;
        for (int i = 0; i < nf; i++) push(dd[i]);
        n = nf * (NCLK + 1) + 2;
        capture(n);
        npop = 0; ndone = 0;
        for (int i = 0; i < n; i++) begin
            f = (i == 0) ? 0 : (i - 1) / (NCLK + 1);
            k = i - f * (NCLK + 1);
            exp_rd = ((i % (NCLK + 1)) == 0) && ((i / (NCLK + 1)) < nf);
            in_frame = (i >= 1) && (f < nf) && (k <= NCLK);
            if (c_rd[i] === 1'b1) npop++;
            if (c_done[i] === 1'b1) ndone++;
            checks++;
            if (c_rd[i] !== exp_rd) begin
                errors++; $display("FAIL b2b_pop idx=%0d got=%b exp=%b", i, c_rd[i], exp_rd);
            end
            checks++;
            if (in_frame) begin
                if (c_tx[i] !== exp_tx(dd[f], k, CPB) || c_busy[i] !== 1'b1 || c_done[i] !== (k == NCLK)) begin
                    errors++;
                    $display("FAIL b2b_frame idx=%0d got tx/busy/done=%b%b%b exp=%b1%b",
                             i, c_tx[i], c_busy[i], c_done[i], exp_tx(dd[f], k, CPB), (k == NCLK));
                end
            end else if (c_tx[i] !== 1'b1 || c_busy[i] !== 1'b0 || c_done[i] !== 1'b0) begin
                errors++; $display("FAIL b2b_idle idx=%0d got=%b%b%b exp=100", i, c_tx[i], c_busy[i], c_done[i]);
            end
        end
        checks++; if (npop != nf) begin errors++; $display("FAIL b2b_npop got=%0d exp=%0d", npop, nf); end
        checks++; if (ndone != nf) begin errors++; $display("FAIL b2b_ndone got=%0d exp=%0d", ndone, nf); end
    endtask

    task automatic test_parity;
        logic e0, e1;
        test_back_to_back(4'hA, 4'h7, 4'h0, 2);
`ifdef NIBBLE_TX_PARITY_EN
        e0 = 1'b0; e1 = 1'b1;
`else
        e0 = 1'b1; e1 = 1'b1;
`endif
        checks++; if (c_tx[5*CPB + 2] !== e0) begin
            errors++; $display("FAIL parity_a got=%b exp=%b", c_tx[5*CPB + 2], e0);
        end
        checks++; if (c_tx[(NCLK + 1) + 5*CPB + 2] !== e1) begin
            errors++; $display("FAIL parity_7 got=%b exp=%b", c_tx[(NCLK + 1) + 5*CPB + 2], e1);
        end
    endtask

    task automatic test_enable;
        int k, ndone;
        push(4'h5); push(4'h6);
        #1;
        checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL en_pop5 got=%b exp=1", fifo_rd_en); end
        repeat (3) @(negedge clk);
        enable = 1'b0;
        capture(NCLK + 4);
        ndone = 0;
        for (int j = 0; j < NCLK + 4; j++) begin
            k = j + 3;
            if (c_done[j] === 1'b1) ndone++;
            checks++;
            if (c_rd[j] !== 1'b0) begin errors++; $display("FAIL en_no_pop idx=%0d got=%b exp=0", j, c_rd[j]); end
            checks++;
            if (k <= NCLK) begin
                if (c_tx[j] !== exp_tx(4'h5, k, CPB) || c_busy[j] !== 1'b1) begin
                    errors++; $display("FAIL en_frame5 k=%0d got tx/busy=%b%b exp=%b1", k, c_tx[j], c_busy[j], exp_tx(4'h5, k, CPB));
                end
            end else if (c_tx[j] !== 1'b1 || c_busy[j] !== 1'b0) begin
                errors++; $display("FAIL en_idle k=%0d got tx/busy=%b%b exp=10", k, c_tx[j], c_busy[j]);
            end
        end
        checks++; if (ndone != 1) begin errors++; $display("FAIL en_done5 got=%0d exp=1", ndone); end
        checks++; if (wr_ptr - rd_ptr != 1) begin errors++; $display("FAIL en_held got=%0d queued exp=1", wr_ptr - rd_ptr); end
        enable = 1'b1;
        capture(NCLK + 2);
        checks++; if (c_rd[0] !== 1'b1) begin errors++; $display("FAIL en_pop6 got=%b exp=1", c_rd[0]); end
        for (int i = 1; i <= NCLK; i++) begin
            checks++;
            if (c_tx[i] !== exp_tx(4'h6, i, CPB) || c_busy[i] !== 1'b1) begin
                errors++; $display("FAIL en_frame6 k=%0d got tx/busy=%b%b exp=%b1", i, c_tx[i], c_busy[i], exp_tx(4'h6, i, CPB));
            end
        end
    endtask

    task automatic test_reset_midframe;
        int npop;
        push(4'h9);
        #1;
        checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL rst_pop got=%b exp=1", fifo_rd_en); end
        repeat (2*CPB + 2) @(negedge clk);
        // second data bit of 9 is 0
        checks++; if (tx !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rst_pre got tx/busy=%b%b exp=01", tx, busy); end
        rstN = 1'b0;
        #1;
        checks++; if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
            errors++; $display("FAIL rst_immediate got tx/busy/done=%b%b%b exp=100", tx, busy, frame_done);
        end
        repeat (2) @(negedge clk);
        checks++; if (tx !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rst_held got=%b%b exp=10", tx, busy); end
        checks++; if (rd_ptr != wr_ptr) begin errors++; $display("FAIL rst_repop got rd=%0d exp=%0d", rd_ptr, wr_ptr); end
        rstN = 1'b1;
        @(negedge clk);
        push(4'hC);
        capture(NCLK + 2);
        npop = 0;
        for (int i = 0; i < NCLK + 2; i++) if (c_rd[i] === 1'b1) npop++;
        checks++; if (npop != 1 || c_rd[0] !== 1'b1) begin errors++; $display("FAIL rst_fresh_pop got=%0d exp=1", npop); end
        for (int i = 1; i <= NCLK; i++) begin
            checks++;
            if (c_tx[i] !== exp_tx(4'hC, i, CPB) || c_busy[i] !== 1'b1 || c_done[i] !== (i == NCLK)) begin
                errors++; $display("FAIL rst_fresh k=%0d got tx/busy/done=%b%b%b exp=%b1%b",
                                   i, c_tx[i], c_busy[i], c_done[i], exp_tx(4'hC, i, CPB), (i == NCLK));
            end
        end
    endtask

    task automatic test_stop2;
        logic [7:0] bits;
        f2_rdata = 4'hF;
        f2_empty = 1'b0;
        #1;
        checks++; if (f2_rd_en !== 1'b1) begin errors++; $display("FAIL stop2_pop got=%b exp=1", f2_rd_en); end
        @(posedge clk);
        #1 f2_empty = 1'b1;
        bits = '0;
        for (int k = 1; k <= NCLK2 + 1; k++) begin
            @(negedge clk);
            if (k <= NCLK2) bits[k-1] = tx2;
            checks++;
            if (k <= NCLK2) begin
                if (tx2 !== exp_tx(4'hF, k, 1) || busy2 !== 1'b1 || done2 !== (k == NCLK2) || f2_rd_en !== 1'b0) begin
                    errors++; $display("FAIL stop2_frame k=%0d got tx/busy/done=%b%b%b exp=%b1%b",
                                       k, tx2, busy2, done2, exp_tx(4'hF, k, 1), (k == NCLK2));
                end
            end else if (tx2 !== 1'b1 || busy2 !== 1'b0 || done2 !== 1'b0) begin
                errors++; $display("FAIL stop2_after got=%b%b%b exp=100", tx2, busy2, done2);
            end
        end
`ifdef NIBBLE_TX_PARITY_EN
        checks++; if (bits !== 8'b11011110) begin errors++; $display("FAIL stop2_bits got=%b exp=11011110", bits); end
`else
        checks++; if (bits[6:0] !== 7'b1111110) begin errors++; $display("FAIL stop2_bits got=%b exp=1111110", bits[6:0]); end
`endif
    endtask

    initial begin
        #2 rstN = 1'b0;
        repeat (3) @(negedge clk);
        test_reset;
        rstN = 1'b1;
        @(negedge clk);
        test_idle_empty;
        test_single;
        test_back_to_back(4'h1, 4'h2, 4'h3, 3);
        test_parity;
        test_enable;
        test_reset_midframe;
        test_stop2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
